sync_fifo_wm: RTL and testbench

Parametrised successor to the team's synchronous stream FIFO. Buffers a valid/ready stream between user-project blocks such as DMA, tap/data engines and AXI-Stream bridges. Adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush and a clearable high-watermark register. Supports depths that are not a power of two. Uses first-word-fall-through output with no combinational path from oready to iready.

---
 rtl/sync_fifo_wm.sv | 72 +++++++
 tb/tb_sync_fifo_wm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wm.sv
// sync_fifo_wm: FWFT valid/ready FIFO with occupancy count, almost flags, flush and clearable high watermark.
module sync_fifo_wm #(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 16,
   parameter int AFULL_THRES  = FIFO_DEPTH - 2,
   parameter int AEMPTY_THRES = 1,
   parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ivalid,
   output logic                  iready,
   input  logic [DATA_WIDTH-1:0] idata,
   output logic                  ovalid,
   input  logic                  oready,
   output logic [DATA_WIDTH-1:0] odata,
   input  logic                  flush,
   input  logic                  clr_wm,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  afull,
   output logic                  aempty,
   output logic [CNT_WIDTH-1:0]  watermark
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_AF = CNT_WIDTH'(AFULL_THRES);
   localparam logic [CNT_WIDTH-1:0] CNT_AE = CNT_WIDTH'(AEMPTY_THRES);
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr, wptr_inc, rptr_inc;
   logic [CNT_WIDTH-1:0] count_next, wm_next;
   logic push, pop;
   assign push = ivalid & iready;
   assign pop = ovalid & oready;
   assign ovalid = count != '0;
   assign odata = mem[rptr];
   // explicit wrap so non-power-of-two depths never index past the last entry
   assign wptr_inc = (wptr == PTR_LAST) ? '0 : wptr + PTR_ONE;
   assign rptr_inc = (rptr == PTR_LAST) ? '0 : rptr + PTR_ONE;
   always_comb begin
      count_next = flush ? '0 : (push & ~pop) ? count + CNT_ONE : (pop & ~push) ? count - CNT_ONE : count;
      wm_next = clr_wm ? count_next : (count_next > watermark) ? count_next : watermark;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         watermark <= '0;
         iready    <= 1'b0;
         afull     <= (AFULL_THRES == 0);
         aempty    <= 1'b1;
      end else begin
         wptr      <= flush ? '0 : push ? wptr_inc : wptr;
         rptr      <= flush ? '0 : pop ? rptr_inc : rptr;
         count     <= count_next;
         watermark <= wm_next;
         iready    <= count_next != CNT_FULL;
         afull     <= count_next >= CNT_AF;
         aempty    <= count_next <= CNT_AE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wptr] <= idata;
      end
   end
endmodule

// File: tb/tb_sync_fifo_wm.sv
// tb_sync_fifo_wm: queue-based reference model checked every cycle, plus directed literal checks, for depths 16 and 5.
module tb_sync_fifo_wm;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        a_ivalid = 0, a_oready = 0, a_flush = 0, a_clr = 0;
   logic [31:0] a_idata = 0;
   logic        a_iready, a_ovalid, a_afull, a_aempty;
   logic [31:0] a_odata;
   logic [4:0]  a_count, a_wm;

   logic        b_ivalid = 0, b_oready = 0, b_flush = 0, b_clr = 0;
   logic [7:0]  b_idata = 0;
   logic        b_iready, b_ovalid, b_afull, b_aempty;
   logic [7:0]  b_odata;
   logic [2:0]  b_count, b_wm;

   sync_fifo_wm #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) u_a (
      .clk(clk), .rst(rst), .ivalid(a_ivalid), .iready(a_iready), .idata(a_idata),
      .ovalid(a_ovalid), .oready(a_oready), .odata(a_odata), .flush(a_flush), .clr_wm(a_clr),
      .count(a_count), .afull(a_afull), .aempty(a_aempty), .watermark(a_wm));

   sync_fifo_wm #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u_b (
      .clk(clk), .rst(rst), .ivalid(b_ivalid), .iready(b_iready), .idata(b_idata),
      .ovalid(b_ovalid), .oready(b_oready), .odata(b_odata), .flush(b_flush), .clr_wm(b_clr),
      .count(b_count), .afull(b_afull), .aempty(b_aempty), .watermark(b_wm));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: a queue holding the FIFO contents, updated on each clock edge
   logic [31:0] aq[$];
   logic [7:0]  bq[$];
   bit a_mrdy = 0, b_mrdy = 0;
   int a_mwm = 0, b_mwm = 0;
   bit model_live = 0;

   initial forever begin
      bit ap, ao, bp, bo;
      @(posedge clk or posedge rst);
      if (rst) begin
         aq.delete(); bq.delete();
         a_mrdy = 0; b_mrdy = 0; a_mwm = 0; b_mwm = 0;
         model_live = 1;
      end else begin
         ap = a_ivalid && a_mrdy;
         ao = aq.size() != 0 && a_oready;
         if (a_flush) aq.delete();
         else begin
            if (ao) void'(aq.pop_front());
            if (ap) aq.push_back(a_idata);
         end
         a_mrdy = aq.size() != 16;
         a_mwm = a_clr ? aq.size() : (aq.size() > a_mwm ? aq.size() : a_mwm);
         bp = b_ivalid && b_mrdy;
         bo = bq.size() != 0 && b_oready;
         if (b_flush) bq.delete();
         else begin
            if (bo) void'(bq.pop_front());
            if (bp) bq.push_back(b_idata);
         end
         b_mrdy = bq.size() != 5;
         b_mwm = b_clr ? bq.size() : (bq.size() > b_mwm ? bq.size() : b_mwm);
      end
   end

   initial forever begin
      @(posedge clk);
      #2;
      if (model_live) begin
         chk("a_count", 32'(a_count), 32'(aq.size()));
         chk("a_iready", 32'(a_iready), 32'(a_mrdy));
         chk("a_ovalid", 32'(a_ovalid), 32'(aq.size() != 0));
         chk("a_afull", 32'(a_afull), 32'(aq.size() >= 14));
         chk("a_aempty", 32'(a_aempty), 32'(aq.size() <= 1));
         chk("a_wm", 32'(a_wm), 32'(a_mwm));
         if (aq.size() != 0) chk("a_odata", a_odata, aq[0]);
         chk("b_count", 32'(b_count), 32'(bq.size()));
         chk("b_iready", 32'(b_iready), 32'(b_mrdy));
         chk("b_ovalid", 32'(b_ovalid), 32'(bq.size() != 0));
         chk("b_afull", 32'(b_afull), 32'(bq.size() >= 3));
         chk("b_aempty", 32'(b_aempty), 32'(bq.size() <= 1));
         chk("b_wm", 32'(b_wm), 32'(b_mwm));
         if (bq.size() != 0) chk("b_odata", 32'(b_odata), 32'(bq[0]));
      end
   end

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_iready", 32'(a_iready), 0);
      chk("rst_ovalid", 32'(a_ovalid), 0);
      chk("rst_odata", a_odata, 0);
      chk("rst_aempty", 32'(a_aempty), 1);
      chk("rst_afull", 32'(a_afull), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_iready", 32'(a_iready), 1);
      chk("rel_count", 32'(a_count), 0);

      for (int i = 0; i < 16; i++) begin
         a_ivalid = 1; a_idata = 32'h11 + 32'(i);
         @(negedge clk);
         if (i == 12) chk("afull_at13", 32'(a_afull), 0);
         if (i == 13) chk("afull_at14", 32'(a_afull), 1);
      end
      a_ivalid = 0;
      chk("fill_count", 32'(a_count), 16);
      chk("fill_iready", 32'(a_iready), 0);
      chk("fill_wm", 32'(a_wm), 16);
      a_oready = 1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_order", a_odata, 32'h11 + 32'(i));
         @(negedge clk);
         if (i == 13) chk("aempty_at2", 32'(a_aempty), 0);
         if (i == 14) chk("aempty_at1", 32'(a_aempty), 1);
      end
      a_oready = 0;
      chk("drain_count", 32'(a_count), 0);

      for (int i = 0; i < 16; i++) begin
         a_ivalid = 1; a_idata = 32'h100 + 32'(i);
         @(negedge clk);
      end
      a_idata = 32'hAB; a_oready = 1;
      @(negedge clk);
      chk("fullpop_count", 32'(a_count), 15);
      chk("fullpop_iready", 32'(a_iready), 1);
      a_oready = 0;
      @(negedge clk);
      a_ivalid = 0;
      chk("fullpop_refill", 32'(a_count), 16);
      a_oready = 1;
      for (int i = 0; i < 16; i++) begin
         chk("fullpop_order", a_odata, (i == 15) ? 32'hAB : 32'h101 + 32'(i));
         @(negedge clk);
      end
      a_oready = 0;

      a_flush = 1; a_clr = 1;
      @(negedge clk);
      a_flush = 0; a_clr = 0;
      chk("clr_wm_zero", 32'(a_wm), 0);
      for (int i = 0; i < 9; i++) begin
         a_ivalid = 1; a_idata = 32'h200 + 32'(i);
         @(negedge clk);
      end
      chk("nine_count", 32'(a_count), 9);
      a_flush = 1; a_idata = 32'hDEAD;
      @(negedge clk);
      a_flush = 0; a_ivalid = 0;
      chk("flush_count", 32'(a_count), 0);
      chk("flush_ovalid", 32'(a_ovalid), 0);
      chk("flush_wm", 32'(a_wm), 9);
      chk("flush_iready", 32'(a_iready), 1);
      a_clr = 1;
      @(negedge clk);
      a_clr = 0;
      chk("clr_wm", 32'(a_wm), 0);

      for (int i = 0; i < 2; i++) begin
         b_ivalid = 1; b_idata = 8'(i);
         @(negedge clk);
      end
      for (int i = 2; i < 200; i++) begin
         b_idata = 8'(i); b_oready = 1;
         chk("b_stream_data", 32'(b_odata), 32'(i - 2));
         chk("b_stream_count", 32'(b_count), 2);
         @(negedge clk);
      end
      b_ivalid = 0;
      for (int i = 198; i < 200; i++) begin
         chk("b_tail_data", 32'(b_odata), 32'(i));
         @(negedge clk);
      end
      b_oready = 0;
      chk("b_empty", 32'(b_count), 0);

      for (int c = 0; c < 10000; c++) begin
         a_ivalid = 1'($urandom_range(0, 1)); a_idata = $urandom;
         a_oready = 1'($urandom_range(0, 1));
         a_flush = $urandom_range(0, 63) == 0; a_clr = $urandom_range(0, 63) == 0;
         b_ivalid = 1'($urandom_range(0, 1)); b_idata = 8'($urandom);
         b_oready = 1'($urandom_range(0, 1));
         b_flush = $urandom_range(0, 63) == 0; b_clr = $urandom_range(0, 63) == 0;
         @(negedge clk);
      end
      a_ivalid = 0; a_oready = 0; a_flush = 0; a_clr = 0;
      b_ivalid = 0; b_oready = 0; b_flush = 0; b_clr = 0;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
